// File: rtl/seg7_pkg.sv
// Shared constants for the scanned 7-segment display: segment patterns {g,f,e,d,c,b,a}
// and digit count.
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 4;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_scan_display_if.sv
// Digit-code input and segment/anode output bundle of the scanned display.
interface seg7_scan_display_if;
   import seg7_pkg::*;

   logic [3:0]            code;
   logic                  load;
   logic [6:0]            seg;
   logic [NUM_DIGITS-1:0] an;

   modport master (output code, output load, input seg, input an);
   modport slave  (input code, input load, output seg, output an);

endinterface

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder; invalid entries blank, codes 10-15 show a dash.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] i_code,
   input  logic       i_valid,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      if (i_valid) begin
         case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit scanned 7-segment driver: a shift-in digit history shown one digit at a time,
// each digit lit for SCAN_DIV cycles.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   seg7_scan_display_if.slave   bus
);

   localparam int unsigned         CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CntW-1:0]     CntMax = CntW'(SCAN_DIV - 1);
   localparam logic [NUM_DIGITS-1:0] AnOne = NUM_DIGITS'(1);

   logic [CntW-1:0]       r_cnt;
   logic [1:0]            r_idx;
   logic [3:0]            r_dig [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] r_vld;
   logic [6:0]            r_seg;
   logic [NUM_DIGITS-1:0] r_an;

   logic                  w_tick;
   logic [6:0]            w_seg;

   assign w_tick = (r_cnt == CntMax);

   // Decode sees pre-edge history, so a load on this edge shows up one cycle later.
   seg7_decode u_decode (
      .i_code  (r_dig[r_idx]),
      .i_valid (r_vld[r_idx]),
      .o_seg   (w_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= '0;
         r_vld <= '0;
         r_seg <= SEG_BLANK;
         r_an  <= '1;
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            r_dig[i] <= '0;
         end
      end else begin
         r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
         if (w_tick) begin
            r_idx <= r_idx + 2'd1;
         end
         if (bus.load) begin
            r_dig[0] <= bus.code;
            for (int i = 1; i < int'(NUM_DIGITS); i++) begin
               r_dig[i] <= r_dig[i-1];
            end
            r_vld <= {r_vld[NUM_DIGITS-2:0], 1'b1};
         end
         r_seg <= w_seg;
         r_an  <= ~(AnOne << r_idx);
      end
   end

   assign bus.seg = r_seg;
   assign bus.an  = r_an;

endmodule
